// File: rtl/pipe_sub3_2stage_vr_pkg.sv
// pipe_sub3_pkg: shared width default and stage-1 payload layout for the 3-operand subtractor
package pipe_sub3_pkg;
  localparam int NBITS = 8;
  typedef struct packed {
    logic [NBITS-1:0] d01;
    logic [NBITS-1:0] in2;
  } sub3_s1_t;
endpackage

// File: rtl/pipe_sub3_2stage_vr_if.sv
// pipe_sub3_2stage_vr_if: producer and consumer valid/ready bundle of the subtractor pipe
interface pipe_sub3_2stage_vr_if import pipe_sub3_pkg::*; #(parameter int nbits = NBITS);
  logic in_val;
  logic in_rdy;
  logic [nbits-1:0] in0;
  logic [nbits-1:0] in1;
  logic [nbits-1:0] in2;
  logic out_val;
  logic out_rdy;
  logic [nbits-1:0] out01;
  logic [nbits-1:0] out;
  modport master (output in_val, in0, in1, in2, out_rdy, input in_rdy, out_val, out01, out);
  modport slave (input in_val, in0, in1, in2, out_rdy, output in_rdy, out_val, out01, out);
endinterface

// File: rtl/pipe_sub3_2stage_vr_stage.sv
// pipe_vr_stage: one elastic valid/ready register slot with combinational ready passthrough
module pipe_vr_stage #(parameter int W = 8) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_val,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_val,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);
  // slot can take new data when empty or when its current content leaves this cycle
  always_comb in_rdy = !out_val || out_rdy;
  // data only captured alongside a valid so idle outputs keep their last value
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_val  <= 1'b0;
      out_data <= '0;
    end else if (in_rdy) begin
      out_val <= in_val;
      if (in_val) out_data <= in_data;
    end
  end
endmodule

// File: rtl/pipe_sub3_2stage_vr.sv
// pipe_sub3_2stage_vr: two-stage elastic pipe computing in0-in1 then in0-in1-in2
module pipe_sub3_2stage_vr import pipe_sub3_pkg::*; #(parameter int nbits = NBITS) (
  input logic clk,
  input logic reset,
  pipe_sub3_2stage_vr_if.slave io
);
  sub3_s1_t s1_in;
  sub3_s1_t s1_q;
  logic s1_val;
  logic s2_rdy;
  logic [2*nbits-1:0] s2_in;
  logic [2*nbits-1:0] s2_q;
  // first difference is formed before stage 1; in2 rides along for stage 2
  always_comb s1_in = '{d01: io.in0 - io.in1, in2: io.in2};
  // second difference is formed between the stages; out01 travels with it
  always_comb s2_in = {s1_q.d01, s1_q.d01 - s1_q.in2};
  // outputs are taken straight from the stage-2 register
  always_comb begin
    io.out01 = s2_q[2*nbits-1:nbits];
    io.out   = s2_q[nbits-1:0];
  end
  pipe_vr_stage #(.W($bits(sub3_s1_t))) u_s1 (
    .clk(clk), .reset(reset),
    .in_val(io.in_val), .in_rdy(io.in_rdy), .in_data(s1_in),
    .out_val(s1_val), .out_rdy(s2_rdy), .out_data(s1_q)
  );
  pipe_vr_stage #(.W(2*nbits)) u_s2 (
    .clk(clk), .reset(reset),
    .in_val(s1_val), .in_rdy(s2_rdy), .in_data(s2_in),
    .out_val(io.out_val), .out_rdy(io.out_rdy), .out_data(s2_q)
  );
endmodule

// File: tb/tb_pipe_sub3_2stage_vr.sv
// tb_pipe_sub3_2stage_vr: queue-model scoreboard plus directed literal checks for the subtractor pipe
module tb_pipe_sub3_2stage_vr;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;
  pipe_sub3_2stage_vr_if io();
  pipe_sub3_2stage_vr dut (.clk(clk), .reset(reset), .io(io.slave));
  typedef struct {
    logic [7:0] d01;
    logic [7:0] d012;
    int c;
  } item_t;
  item_t q[$];
  item_t lg[$];
  int cyc = 0, nacc = 0, npop = 0, ncmp = 0, nerr = 0;
  logic [7:0] m01, m012;
  logic vexp;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    io.in0 = a;
    io.in1 = b;
    io.in2 = c;
    io.in_val = 1'b1;
  endtask
  // model: transactions in flight, stamped with their acceptance edge
  always @(posedge clk) begin
    cyc++;
    if (!reset) q.delete();
    else begin
      if (io.out_val && io.out_rdy) begin
        lg.push_back('{io.out01, io.out, cyc});
        npop++;
        if (q.size() > 0) void'(q.pop_front());
      end
      if (io.in_val && io.in_rdy) begin
        nacc++;
        m01 = io.in0 - io.in1;
        m012 = m01 - io.in2;
        q.push_back('{m01, m012, cyc});
      end
    end
  end
  // compare: in_rdy from occupancy, out_val once the oldest item has seen one more edge
  always @(negedge clk) begin
    if (reset) begin
      chk("in_rdy", io.in_rdy, (q.size() < 2) || io.out_rdy);
      vexp = q.size() > 0 && q[0].c < cyc;
      chk("out_val", io.out_val, vexp);
      if (vexp && io.out_val) begin
        chk("out01", io.out01, q[0].d01);
        chk("out", io.out, q[0].d012);
      end
    end
  end
  initial begin
    int acc, a0, p0, base;
    logic [7:0] e01 [4];
    logic [7:0] e012 [4];
    io.in_val = 0; io.out_rdy = 0; io.in0 = 0; io.in1 = 0; io.in2 = 0;
    repeat (2) step();
    chk("rst_out_val", io.out_val, 0);
    chk("rst_out", io.out, 0);
    chk("rst_out01", io.out01, 0);
    reset = 1;
    #1;
    chk("rst_in_rdy", io.in_rdy, 1);
    lg.delete();
    io.out_rdy = 1;
    drive(10, 3, 2);
    step();
    acc = cyc;
    io.in_val = 0;
    repeat (3) step();
    chk("single_cnt", lg.size(), 1);
    if (lg.size() == 1) begin
      chk("single_out01", lg[0].d01, 8'd7);
      chk("single_out", lg[0].d012, 8'd5);
      chk("single_lat", lg[0].c - acc, 2);
    end
    chk("single_idle", io.out_val, 0);
    lg.delete();
    e01 = '{8'hFF, 8'h00, 8'h7F, 8'hFB};
    e012 = '{8'hFF, 8'hFF, 8'h7F, 8'hE7};
    drive(0, 1, 0); step();
    drive(0, 0, 1); step();
    drive(8'h80, 1, 0); step();
    drive(5, 10, 20); step();
    io.in_val = 0;
    repeat (4) step();
    chk("stream_cnt", lg.size(), 4);
    for (int i = 0; i < 4 && i < lg.size(); i++) begin
      chk("stream_out01", lg[i].d01, e01[i]);
      chk("stream_out", lg[i].d012, e012[i]);
      chk("stream_gap", lg[i].c - lg[0].c, i);
    end
    lg.delete();
    io.out_rdy = 0;
    drive(9, 1, 1); step();
    drive(8, 1, 1); step();
    chk("bp_in_rdy", io.in_rdy, 0);
    drive(7, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_val", io.out_val, 1);
      chk("bp_hold_out", io.out, 8'd7);
    end
    io.out_rdy = 1;
    #1;
    chk("bp_resume_rdy", io.in_rdy, 1);
    step();
    io.in_val = 0;
    repeat (4) step();
    chk("bp_cnt", lg.size(), 3);
    for (int i = 0; i < 3 && i < lg.size(); i++) chk("bp_order", lg[i].d012, 7 - i);
    io.out_rdy = 0;
    drive(1, 0, 0); step();
    drive(2, 0, 0); step();
    drive(3, 0, 0);
    io.out_rdy = 1;
    #1;
    chk("sim_in_rdy", io.in_rdy, 1);
    chk("sim_out_val", io.out_val, 1);
    a0 = nacc; p0 = npop;
    step();
    chk("sim_acc", nacc - a0, 1);
    chk("sim_pop", npop - p0, 1);
    io.in_val = 0;
    repeat (4) step();
    io.out_rdy = 0;
    drive(1, 0, 0); step();
    drive(2, 0, 0); step();
    io.in_val = 0;
    reset = 0;
    step();
    reset = 1;
    chk("mid_rst_val", io.out_val, 0);
    lg.delete();
    io.out_rdy = 1;
    drive(4, 4, 4); step();
    io.in_val = 0;
    repeat (4) step();
    chk("mid_rst_cnt", lg.size(), 1);
    if (lg.size() == 1) begin
      chk("mid_rst_out01", lg[0].d01, 8'h00);
      chk("mid_rst_out", lg[0].d012, 8'hFC);
    end
    base = nacc;
    p0 = npop;
    for (int i = 0; i < 5000 && nacc - base < 200; i++) begin
      io.in_val = 1'($urandom_range(1));
      io.in0 = 8'($urandom);
      io.in1 = 8'($urandom);
      io.in2 = 8'($urandom);
      io.out_rdy = $urandom_range(3) != 0;
      step();
    end
    io.in_val = 0;
    io.out_rdy = 1;
    repeat (5) step();
    chk("rand_acc", nacc - base, 200);
    chk("rand_pop", npop - p0, 200);
    chk("rand_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
